// File: rtl/mem_server.sv
// mem_server: single-ported halfword memory that serves an instruction-fetch
// port (16-bit) and a data port (32-bit, two halfword beats), one access at
// a time through a small FSM (IDLE, FETCH, DLO, DHI, RESP).
//
// Optional feature: define MEM_ALIGN_CHECK_EN to reject data accesses whose
// byte address is not word aligned (o_d_err pulses with o_d_ready, no access).
// Without it the low address bits are ignored and o_d_err stays 0.
//
// Ports:
//   i_clk        clock, all state changes on the rising edge
//   i_rst        synchronous active-high reset
//   i_if_req     fetch request, held until o_if_ready
//   i_if_addr    fetch byte address
//   o_if_ready   one-cycle fetch completion pulse
//   o_if_data    fetched halfword (holds between fetches)
//   i_d_action   data op: 00 none, 01 read, 10 write, 11 none
//   i_d_addr     data byte address
//   i_d_val      write data
//   o_d_ready    one-cycle data completion pulse
//   o_d_val      read data (holds between reads)
//   o_d_err      misalignment flag, pulses with o_d_ready
module mem_server #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_ready,
    output logic [15:0] o_if_data,
    input  logic [1:0]  i_d_action,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_val,
    output logic        o_d_ready,
    output logic [31:0] o_d_val,
    output logic        o_d_err
);

    localparam int unsigned HW_W  = ADDR_W - 1;
    localparam int unsigned DEPTH = 1 << HW_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_DLO   = 3'd2;
    localparam logic [2:0] S_DHI   = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [15:0] mem [0:DEPTH-1];

    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic            mis_pend;
    logic            mis_pend_nxt;
    logic            if_ready_nxt;
    logic [15:0]     if_data_nxt;
    logic            d_ready_nxt;
    logic [31:0]     d_val_nxt;
    logic            d_err_nxt;

    logic            mem_we;
    logic [HW_W-1:0] mem_waddr;
    logic [15:0]     mem_wdata;

    logic            d_op_c;
    logic            d_rd_c;
    logic            d_wr_c;
    logic            d_misaligned_c;
    logic [HW_W-1:0] lo_idx_c;
    logic [HW_W-1:0] hi_idx_c;
    logic [HW_W-1:0] if_idx_c;

    // Address bits outside the decoded range are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{i_if_addr[31:ADDR_W], i_if_addr[0],
                           i_d_addr[31:ADDR_W], i_d_addr[1:0]};

    // Request decode; halfword indices of the word base and base+2.
    always_comb begin
        d_rd_c   = (i_d_action == 2'b01);
        d_wr_c   = (i_d_action == 2'b10);
        d_op_c   = d_rd_c | d_wr_c;
        lo_idx_c = {i_d_addr[ADDR_W-1:2], 1'b0};
        hi_idx_c = {i_d_addr[ADDR_W-1:2], 1'b1};
        if_idx_c = i_if_addr[ADDR_W-1:1];
`ifdef MEM_ALIGN_CHECK_EN
        d_misaligned_c = (i_d_addr[1:0] != 2'b00);
`else
        d_misaligned_c = 1'b0;
`endif
    end

    // Next-state, next-output and memory write control.
    always_comb begin
        state_nxt    = state;
        mis_pend_nxt = mis_pend;
        if_ready_nxt = 1'b0;
        if_data_nxt  = o_if_data;
        d_ready_nxt  = 1'b0;
        d_val_nxt    = o_d_val;
        d_err_nxt    = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = lo_idx_c;
        mem_wdata    = i_d_val[15:0];

        case (state)
            S_IDLE: begin
                mis_pend_nxt = 1'b0;
                // Data has priority; a pending fetch simply waits.
                if (d_op_c) begin
                    if (d_misaligned_c) begin
                        mis_pend_nxt = 1'b1;
                        state_nxt    = S_DHI;
                    end else begin
                        state_nxt = S_DLO;
                    end
                end else if (i_if_req) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if_data_nxt  = mem[if_idx_c];
                if_ready_nxt = 1'b1;
                state_nxt    = S_RESP;
            end
            S_DLO: begin
                if (d_rd_c) begin
                    d_val_nxt[15:0] = mem[lo_idx_c];
                end
                if (d_wr_c) begin
                    mem_we = 1'b1;
                end
                state_nxt = S_DHI;
            end
            S_DHI: begin
                d_ready_nxt = 1'b1;
                if (mis_pend) begin
                    // Rejected access: flag only, no memory traffic.
                    d_err_nxt = 1'b1;
                end else begin
                    if (d_rd_c) begin
                        d_val_nxt[31:16] = mem[hi_idx_c];
                    end
                    if (d_wr_c) begin
                        mem_we    = 1'b1;
                        mem_waddr = hi_idx_c;
                        mem_wdata = i_d_val[31:16];
                    end
                end
                state_nxt = S_RESP;
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            mis_pend   <= 1'b0;
            o_if_ready <= 1'b0;
            o_if_data  <= 16'h0000;
            o_d_ready  <= 1'b0;
            o_d_val    <= 32'h0000_0000;
            o_d_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            mis_pend   <= mis_pend_nxt;
            o_if_ready <= if_ready_nxt;
            o_if_data  <= if_data_nxt;
            o_d_ready  <= d_ready_nxt;
            o_d_val    <= d_val_nxt;
            o_d_err    <= d_err_nxt;
        end
    end

    // Storage survives reset; a reset edge only suppresses the write due then.
    always_ff @(posedge i_clk) begin
        if (mem_we && !i_rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: doc/mem_server.md
MEM_SERVER -- requirements
Module: mem_server

Interface
REQ-001 Parameter ADDR_W, default 12, width of the byte address space the block decodes; array holds 2**(ADDR_W-1) halfwords.
REQ-002 i_clk  in  1  sole clock, all state changes on rising edge.
REQ-003 i_rst  in  1  reset, synchronous, active-high.
REQ-004 i_if_req  in  1  instruction-fetch request, held until o_if_ready.
REQ-005 i_if_addr  in  32  fetch byte address.
REQ-006 o_if_ready  out  1  one-cycle fetch completion pulse.
REQ-007 o_if_data  out  16  fetched halfword, valid while o_if_ready=1.
REQ-008 i_d_action  in  2  data op: 00 none, 01 read, 10 write, 11 treated as none; held until o_d_ready.
REQ-009 i_d_addr  in  32  data byte address.
REQ-010 i_d_val  in  32  write data.
REQ-011 o_d_ready  out  1  one-cycle data completion pulse.
REQ-012 o_d_val  out  32  read data, valid while o_d_ready=1.
REQ-013 o_d_err  out  1  misalignment flag, pulses with o_d_ready (see Configuration).

Function
REQ-014 Storage: single halfword array; address bits above ADDR_W-1 ignored, so addresses wrap modulo 2**ADDR_W.
REQ-015 FSM states: IDLE, FETCH, DLO, DHI, RESP; one state per cycle, no other states.
REQ-016 IDLE: i_d_action in {01,10} -> DLO; else i_if_req=1 -> FETCH; else stay IDLE.
REQ-017 Both requests pending in IDLE: data wins; fetch stays pending, no loss.
REQ-018 FETCH: read halfword at i_if_addr[ADDR_W-1:1] into o_if_data, set o_if_ready=1, -> RESP.
REQ-019 DLO: read captures halfword at word base into o_d_val[15:0]; write stores i_d_val[15:0] there; -> DHI.
REQ-020 DHI: read captures base+2 into o_d_val[31:16]; write stores i_d_val[31:16]; set o_d_ready=1; -> RESP.
REQ-021 Word layout little-endian: low half at base, high half at base+2.
REQ-022 RESP: ready pulse visible this cycle only; no request sampled; -> IDLE.
REQ-023 Latency: request high at edge k in IDLE -> fetch ready during cycle after edge k+1; data ready during cycle after edge k+2.
REQ-024 Requester drops request during the ready cycle; request still high on return to IDLE is a new request.
REQ-025 o_if_data/o_d_val hold last captured value outside ready cycles.
REQ-026 Write followed by read of same address returns the written value (no stale bypass path).

Reset
REQ-027 i_rst=1 at an edge: state IDLE, o_if_ready=0, o_d_ready=0, o_d_err=0, o_if_data=0, o_d_val=0; overrides all transitions.
REQ-028 Array contents not affected by reset.
REQ-029 Reset in DHI of a write: low half already stored, high half unchanged, no ready pulse.

Configuration
REQ-030 Macro MEM_ALIGN_CHECK_EN defined: data address with i_d_addr[1:0]!=00 goes IDLE->DHI directly without memory access, o_d_ready=1 and o_d_err=1 together, o_d_val unchanged, no write; fetch with i_if_addr[0]=1 unaffected (bit ignored).
REQ-031 Macro undefined: i_d_addr[1:0] and i_if_addr[0] forced to zero, o_d_err tied 0, normal access.

Verification
REQ-032 Write 0xDEADBEEF at 0x010, then read 0x010 -> o_d_val=0xDEADBEEF, each ready 3 cycles after request assertion.
REQ-033 Fetch 0x010 after REQ-032 write -> o_if_data=0xBEEF; fetch 0x012 -> 0xDEAD; ready 2 cycles after request.
REQ-034 i_if_req and data read asserted same cycle -> o_d_ready first, o_if_ready exactly 3 cycles later (RESP, IDLE, FETCH).
REQ-035 ADDR_W=12, write 0x11223344 at 0x1000 -> read 0x000 returns 0x11223344 (wrap).
REQ-036 With MEM_ALIGN_CHECK_EN, write at 0x013 -> o_d_ready=1,o_d_err=1 after 2 cycles, memory at 0x010 unchanged; without it, same write lands at 0x010, o_d_err=0.
REQ-037 Write 0xAAAABBBB at 0x020 over 0x00000000, i_rst pulsed in DHI -> read 0x020 returns 0x0000BBBB, all outputs 0 after reset edge.
